// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake and drives every datapath enable and select.
// Optional feature macro: JUMP_EN (adds the j instruction path through the JUMP state).
module multicycle_controller (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiEx   = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
`ifdef JUMP_EN
  localparam logic [5:0] OpJ     = 6'h02;
`endif

  state_e state_q, state_d;
  state_e dec_st;

  // State register with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (opcode == OpLw || opcode == OpSw) state_d = StMemAddr;
        else if (opcode == OpRtype)           state_d = StExecute;
        else if (opcode == OpBeq)             state_d = StBranch;
        else if (opcode == OpAddi)            state_d = StAddiEx;
`ifdef JUMP_EN
        else if (opcode == OpJ)               state_d = StJump;
`endif
        else                                  state_d = StFetch;
      end
      StMemAddr:  state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StExecute:  state_d = StAluWb;
      StAddiEx:   state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
  end

  // While clear is low the selects decode as FETCH; enables are masked below.
  assign dec_st = clear_n ? state_q : StFetch;

  // Output decode of the current state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    unique case (dec_st)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        illegal   = !(opcode == OpLw || opcode == OpSw || opcode == OpRtype ||
`ifdef JUMP_EN
                      opcode == OpJ ||
`endif
                      opcode == OpBeq || opcode == OpAddi);
      end
      StMemAddr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRead: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
`ifdef JUMP_EN
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
`endif
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Clear masks every enable and pulse.
    if (!clear_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences the multi-cycle MIPS datapath: PC register, instruction register, unified memory, register file and ALU. It decodes the 6-bit opcode latched in the instruction register and drives every enable and mux select, one state per clock. It also stalls on a memory ready handshake. It sits beside the datapath top level and is the only source of PC write enables.

## Interface
- Parameters: none; the opcode set and state encoding are fixed.
- clock  input  1  rising-edge system clock
- clear_n  input  1  synchronous active-low reset
- opcode  input  6  instruction bits [31:26] from instruction register
- mem_ready  input  1  memory completed current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (gated in datapath)
- pc_source  output  2  00 ALU result, 01 ALU out register, 10 jump target
- i_or_d  output  1  memory address: 0 PC, 1 ALU out register
- mem_read, mem_write  output  1 each  memory strobes
- ir_write  output  1  instruction register load
- reg_write  output  1  register file write
- reg_dst  output  1  write register: 0 rt, 1 rd
- mem_to_reg  output  1  write data: 0 ALU out, 1 memory data register
- alu_src_a  output  1  0 PC, 1 register A
- alu_src_b  output  2  00 register B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  output  2  00 add, 01 subtract, 10 funct field
- instr_done  output  1  one-cycle pulse in final state of each instruction
- illegal  output  1  one-cycle pulse in DECODE for unsupported opcode
- state  output  4  current state (debug)

## Operation
- States: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12–15 are unreachable and return to FETCH on the next edge.
- Outputs are combinational decodes of the state register. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 to compute the branch target. Next state by opcode:
  - 0x23 (lw) or 0x2B (sw) -> MEMADDR
  - 0x00 (R-type) -> EXECUTE
  - 0x04 (beq) -> BRANCH
  - 0x08 (addi) -> ADDIEX
  - 0x02 (j) -> JUMP
  - anything else -> FETCH with illegal=1
- MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next is FETCH.
- MEMWRITE: mem_write=1, i_or_d=1. Holds until mem_ready; instr_done=mem_ready; then goes to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next is ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next is FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next is FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next is ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next is FETCH.
- The opcode is sampled only in DECODE and in MEMADDR (lw/sw split); it is ignored elsewhere.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

## Timing
- Reset: a rising edge with clear_n=0 sets state=FETCH. This applies from any state, including mid-stall.
- While clear_n=0, every enable (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) and both pulses (instr_done, illegal) are forced to 0. Selects show their FETCH values.
- First fetch request: in the cycle after clear_n returns to 1.
- Cycles per instruction with zero wait (mem_ready held 1):
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal 2
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Enables stay asserted and no write commits until mem_ready=1.
- instr_done is high for exactly one cycle per completed instruction. A FETCH always follows it.

## Configuration
- JUMP_EN: defined -> opcode 0x02 takes DECODE->JUMP->FETCH as above.
- JUMP_EN undefined -> JUMP state logic removed and encoding 9 is treated as unreachable. Opcode 0x02 is illegal: illegal=1 in DECODE, next FETCH, no PC load beyond PC+4.

## Test plan
- Hold clear_n=0 for 2 edges from state 7 -> state=0, all enables 0 while clear_n low; first cycle after release mem_read=1, pc_write=1 (mem_ready=1).
- lw (0x23), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write and mem_to_reg high only in state 4; instr_done once.
- sw (0x2B) with mem_ready low 3 cycles in MEMWRITE -> mem_write high 4 consecutive cycles, instr_done only on the 4th, then state 0.
- beq (0x04) -> states 0,1,8,0; state 8 has pc_write_cond=1, pc_source=01, alu_op=01, pc_write=0.
- R-type (0x00) then addi (0x08) back to back -> states 0,1,6,7,0,1,10,11; reg_dst=1 in 7, 0 in 11.
- Opcode 0x3F, and 0x02 with JUMP_EN undefined -> illegal pulse in state 1, next state 0, reg_write/mem_write never asserted.
